// File: rtl/fsx_pkg.sv
// rtl/fsx_pkg.sv - shared constants and colour expansion for the layer compositor
package fsx_pkg;

    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_R_W   = 3;
    localparam int RGB_G_W   = 3;
    localparam int RGB_B_W   = 2;

    localparam logic [3:0] CFG_EN    = 4'd0;
    localparam logic [3:0] CFG_KEYEN = 4'd1;
    localparam logic [3:0] CFG_BG    = 4'd2;
    localparam logic [3:0] CFG_KEY0  = 4'd3;

    localparam int LATENCY = 3;

    // Zero stays black; anything else is MSB-aligned with ones filled below so full scale reaches all ones.
    function automatic logic [9:0] fsx_expand(input logic [2:0] v, input int src_w, input int out_w);
        logic [9:0] res;
        int         sh;
        sh  = out_w - src_w;
        res = '0;
        if (v != 3'd0)
            res = (10'(v) << sh) | ((10'd1 << sh) - 10'd1);
        return res;
    endfunction

endpackage

// File: rtl/fsx_cfg_regs.sv
// rtl/fsx_cfg_regs.sv - shadow/active config registers, vsync commit, frame interrupt and counter
module fsx_cfg_regs
    import fsx_pkg::*;
#(
    parameter int N_LAYERS    = 2,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vs_in,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [7:0]             cfg_wdata,
    output logic [N_LAYERS-1:0]    en,
    output logic [N_LAYERS-1:0]    keyen,
    output logic [7:0]             bg,
    output logic [8*N_LAYERS-1:0]  keys,
    output logic                   frame_drawn,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    logic [N_LAYERS-1:0]   sh_en;
    logic [N_LAYERS-1:0]   sh_keyen;
    logic [7:0]            sh_bg;
    logic [8*N_LAYERS-1:0] sh_keys;
    logic                  vs_q;
    logic                  frame_event;

    assign frame_event = vs_in && !vs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_en       <= '1;
            sh_keyen    <= '1;
            sh_bg       <= '0;
            sh_keys     <= '0;
            en          <= '1;
            keyen       <= '1;
            bg          <= '0;
            keys        <= '0;
            vs_q        <= 1'b0;
            frame_drawn <= 1'b0;
            frame_count <= '0;
        end else begin
            vs_q        <= vs_in;
            frame_drawn <= frame_event;
            // Commit copies the shadow as it stood before any write in this same cycle.
            if (frame_event) begin
                en          <= sh_en;
                keyen       <= sh_keyen;
                bg          <= sh_bg;
                keys        <= sh_keys;
                frame_count <= frame_count + FRAME_CNT_W'(1);
            end
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_EN:    sh_en    <= cfg_wdata[N_LAYERS-1:0];
                    CFG_KEYEN: sh_keyen <= cfg_wdata[N_LAYERS-1:0];
                    CFG_BG:    sh_bg    <= cfg_wdata;
                    default:   ;
                endcase
                for (int i = 0; i < N_LAYERS; i++) begin
                    if (cfg_addr == CFG_KEY0 + 4'(i))
                        sh_keys[8*i +: 8] <= cfg_wdata;
                end
            end
        end
    end

endmodule

// File: rtl/fsx_layer_compositor.sv
// rtl/fsx_layer_compositor.sv - N-layer RGB332 priority/colour-key mixer with expansion and sync delay
module fsx_layer_compositor
    import fsx_pkg::*;
#(
    parameter int N_LAYERS    = 2,
    parameter int OUT_W       = 8,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*N_LAYERS-1:0]  layer_rgb,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   blank_in,
    input  logic                   cfg_we,
    input  logic [3:0]             cfg_addr,
    input  logic [7:0]             cfg_wdata,
    output logic [OUT_W-1:0]       r_out,
    output logic [OUT_W-1:0]       g_out,
    output logic [OUT_W-1:0]       b_out,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   blank_out,
    output logic                   frame_drawn,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    logic [N_LAYERS-1:0]   en;
    logic [N_LAYERS-1:0]   keyen;
    logic [7:0]            bg;
    logic [8*N_LAYERS-1:0] keys;

    fsx_cfg_regs #(
        .N_LAYERS    (N_LAYERS),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_cfg (
        .clk         (clk),
        .reset       (reset),
        .vs_in       (vs_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .en          (en),
        .keyen       (keyen),
        .bg          (bg),
        .keys        (keys),
        .frame_drawn (frame_drawn),
        .frame_count (frame_count)
    );

    logic [N_LAYERS-1:0]   opaque;
    logic [8*N_LAYERS-1:0] s1_rgb;
    logic [N_LAYERS-1:0]   s1_opaque;
    logic [7:0]            s1_bg;
    logic [2:0]            s1_sync;
    logic [7:0]            sel;
    logic [7:0]            s2_pix;
    logic [2:0]            s2_sync;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < N_LAYERS; i++)
            opaque[i] = en[i] && !(keyen[i] && (layer_rgb[8*i +: 8] == keys[8*i +: 8]));
    end

    // Scan from the lowest priority upward so layer 0 wins last.
    always_comb begin
        sel = s1_bg;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (s1_opaque[i])
                sel = s1_rgb[8*i +: 8];
        end
    end

    // Sync vectors are {hs, vs, blank}; cleared stages read as blanked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_rgb    <= '0;
            s1_opaque <= '0;
            s1_bg     <= '0;
            s1_sync   <= 3'b001;
            s2_pix    <= '0;
            s2_sync   <= 3'b001;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
            hs_out    <= 1'b0;
            vs_out    <= 1'b0;
            blank_out <= 1'b1;
        end else begin
            s1_rgb    <= layer_rgb;
            s1_opaque <= opaque;
            s1_bg     <= bg;
            s1_sync   <= {hs_in, vs_in, blank_in};
            s2_pix    <= sel;
            s2_sync   <= s1_sync;
            hs_out    <= s2_sync[2];
            vs_out    <= s2_sync[1];
            blank_out <= s2_sync[0];
            if (s2_sync[0]) begin
                r_out <= '0;
                g_out <= '0;
                b_out <= '0;
            end else begin
                r_out <= OUT_W'(fsx_expand(s2_pix[RGB_R_LSB +: RGB_R_W], RGB_R_W, OUT_W));
                g_out <= OUT_W'(fsx_expand(s2_pix[RGB_G_LSB +: RGB_G_W], RGB_G_W, OUT_W));
                b_out <= OUT_W'(fsx_expand({1'b0, s2_pix[RGB_B_LSB +: RGB_B_W]}, RGB_B_W, OUT_W));
            end
        end
    end

endmodule

// File: tb/tb_fsx_layer_compositor.sv
// tb/tb_fsx_layer_compositor.sv - scoreboard bench with behavioural mixer model and randomized traffic
module tb_fsx_layer_compositor;

    localparam int N  = 2;
    localparam int OW = 8;
    localparam int FW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*N-1:0]  layer_rgb;
    logic            hs_in, vs_in, blank_in, cfg_we;
    logic [3:0]      cfg_addr;
    logic [7:0]      cfg_wdata;
    logic [OW-1:0]   r_out, g_out, b_out;
    logic            hs_out, vs_out, blank_out, frame_drawn;
    logic [FW-1:0]   frame_count;

    fsx_layer_compositor #(.N_LAYERS(N), .OUT_W(OW), .FRAME_CNT_W(FW)) dut (
        .clk(clk), .reset(rst_n), .layer_rgb(layer_rgb), .hs_in(hs_in), .vs_in(vs_in),
        .blank_in(blank_in), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .hs_out(hs_out), .vs_out(vs_out),
        .blank_out(blank_out), .frame_drawn(frame_drawn), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fd_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: shadow/active configuration as plain values
    logic [7:0]  sh_en, sh_keyen, sh_bg, act_en, act_keyen, act_bg;
    logic [7:0]  sh_key [N];
    logic [7:0]  act_key [N];
    logic        m_vs_prev;
    logic        exp_fd;
    int          exp_fc;
    logic [26:0] exp_q [$];

    function automatic int expand(input int v, input int w);
        return (v == 0) ? 0 : (v + 1) * (1 << (OW - w)) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_en = 8'hFF; sh_keyen = 8'hFF; sh_bg = 8'h00;
            act_en = 8'hFF; act_keyen = 8'hFF; act_bg = 8'h00;
            for (int i = 0; i < N; i++) begin
                sh_key[i] = 8'h00;
                act_key[i] = 8'h00;
            end
            m_vs_prev = 1'b0;
            exp_fd = 1'b0;
            exp_fc = 0;
            exp_q.delete();
            exp_q.push_back(27'h1);
            exp_q.push_back(27'h1);
        end else begin
            logic [7:0] pix, chosen;
            logic       found;
            logic       fe;
            found  = 1'b0;
            chosen = act_bg;
            for (int i = 0; i < N; i++) begin
                pix = layer_rgb[8*i +: 8];
                if (!found && act_en[i] && !(act_keyen[i] && pix == act_key[i])) begin
                    chosen = pix;
                    found  = 1'b1;
                end
            end
            if (blank_in)
                exp_q.push_back({24'h0, hs_in, vs_in, 1'b1});
            else
                exp_q.push_back({8'(expand(int'(chosen[7:5]), 3)), 8'(expand(int'(chosen[4:2]), 3)),
                                 8'(expand(int'(chosen[1:0]), 2)), hs_in, vs_in, 1'b0});
            fe = vs_in && !m_vs_prev;
            m_vs_prev = vs_in;
            exp_fd = fe;
            if (fe) begin
                exp_fc = (exp_fc + 1) % (1 << FW);
                act_en = sh_en; act_keyen = sh_keyen; act_bg = sh_bg;
                for (int i = 0; i < N; i++) act_key[i] = sh_key[i];
            end
            if (cfg_we) begin
                if (cfg_addr == 4'd0) sh_en = {6'h0, cfg_wdata[1:0]};
                if (cfg_addr == 4'd1) sh_keyen = {6'h0, cfg_wdata[1:0]};
                if (cfg_addr == 4'd2) sh_bg = cfg_wdata;
                for (int i = 0; i < N; i++)
                    if (int'(cfg_addr) == 3 + i) sh_key[i] = cfg_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out", {r_out, g_out, b_out, hs_out, vs_out, blank_out}, 32'h1);
            check("reset_irq", {frame_drawn, frame_count}, 32'h0);
        end else begin
            if (exp_q.size() == 3) begin
                logic [26:0] e;
                e = exp_q.pop_front();
                check("pixel", {r_out, g_out, b_out, hs_out, vs_out, blank_out}, e);
            end
            check("frame_drawn", frame_drawn, exp_fd);
            check("frame_count", frame_count, exp_fc);
            if (frame_drawn) fd_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    task automatic vs_pulse(input int w);
        vs_in = 1'b1;
        tick(w);
        vs_in = 1'b0;
        tick(3);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h1C;
            2: return 8'hE0;
            3: return 8'h03;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b1;
        layer_rgb = {8'hE0, 8'h00};
        hs_in = 0; vs_in = 0; blank_in = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        @(negedge clk);
        check("legacy_key_rgb", {r_out, g_out, b_out}, 24'hFF0000);

        layer_rgb = {8'hE0, 8'h1C};
        tick(3);
        @(negedge clk);
        check("priority_l0", {r_out, g_out}, 16'h00FF);
        cfg_write(4'd0, 8'h02);
        vs_pulse(2);
        tick(3);
        @(negedge clk);
        check("en_mask_commit", r_out, 32'hFF);

        layer_rgb = {8'h00, 8'h00};
        cfg_write(4'd2, 8'h03);
        tick(5);
        @(negedge clk);
        check("shadow_hold", b_out, 32'h0);
        vs_pulse(5);
        tick(1);
        @(negedge clk);
        check("bg_commit", {r_out, b_out}, 16'h00FF);

        vs_in = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_wdata = 8'hE0;
        tick(1);
        cfg_we = 1'b0;
        tick(4);
        vs_in = 1'b0;
        tick(3);
        @(negedge clk);
        check("coincident_hold", {r_out, b_out}, 16'h00FF);
        vs_pulse(5);
        tick(1);
        @(negedge clk);
        check("coincident_next", {r_out, b_out}, 16'hFF00);

        layer_rgb = {8'h1C, 8'hE0};
        for (int i = 0; i < 40; i++) begin
            hs_in = 1'($urandom);
            blank_in = 1'($urandom);
            tick(1);
        end
        hs_in = 0; blank_in = 0;

        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        fd_seen = 0;
        repeat (3) vs_pulse(5);
        check("irq_pulses3", fd_seen, 32'd3);
        check("frame_count3", frame_count, 32'd3);
        repeat (2) vs_pulse(5);
        check("irq_pulses5", fd_seen, 32'd5);
        check("frame_count_wrap", frame_count, 32'd1);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_out", {r_out, g_out, b_out, hs_out, vs_out, blank_out}, 32'h1);
        check("async_reset_irq", {frame_drawn, frame_count}, 32'h0);
        vs_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        vs_in = 1'b0;

        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) layer_rgb[8*i +: 8] = pick();
            hs_in = ($urandom_range(0, 7) == 0);
            blank_in = ($urandom_range(0, 9) == 0);
            vs_in = ((c % 37) < 3);
            if ($urandom_range(0, 5) == 0) begin
                cfg_we = 1'b1;
                cfg_addr = 4'($urandom_range(0, 7));
                cfg_wdata = (cfg_addr >= 4'd2) ? pick() : 8'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            tick(1);
        end
        cfg_we = 1'b0; vs_in = 0; blank_in = 0; hs_in = 0;
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsx_layer_compositor.md
Name: fsx_layer_compositor

Overview:
- Parametrised successor of the two-plane frame synthesizer mixer.
- Merges N_LAYERS RGB332 pixel streams using per-layer enable masks, colour keys and a fixed priority order (layer 0 highest).
- Expands the result to OUT_W bits per channel, delays the sync/blank signals to match, and generates the frame-drawn interrupt and a frame counter.
- Sits between the plane renderers/timing mux and the HDMI/NTSC encoders, in the clkMuxOut domain.

Parameters:
- N_LAYERS, 2, number of input planes (1..8).
- OUT_W, 8, output bits per colour channel (3..10).
- FRAME_CNT_W, 16, frame counter width.

Ports:
- clk  in  1  pixel-rate clock.
- reset  in  1  asynchronous, active-low reset.
- layer_rgb  in  8*N_LAYERS  RGB332 per layer, layer i at [8i+7:8i] as {r[2:0], g[2:0], b[1:0]}.
- hs_in  in  1  hsync from the timing source.
- vs_in  in  1  vsync, active-high.
- blank_in  in  1  blanking, high = blank.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  config register address.
- cfg_wdata  in  8  config write data.
- r_out  out  OUT_W  red.
- g_out  out  OUT_W  green.
- b_out  out  OUT_W  blue.
- hs_out  out  1  hsync delayed by LATENCY.
- vs_out  out  1  vsync delayed by LATENCY.
- blank_out  out  1  blank delayed by LATENCY.
- frame_drawn  out  1  one-cycle interrupt pulse.
- frame_count  out  FRAME_CNT_W  frames since reset.

Behaviour:
- Config map; writes go to shadow registers:
  - 0 = layer enable mask [N_LAYERS-1:0].
  - 1 = key-enable mask.
  - 2 = background RGB332.
  - 3+i = key colour of layer i.
  - Unused bits and unmapped addresses are ignored; there is no readback.
- Shadow reset values: enable = all ones, key-enable = all ones, background = 0x00, keys = 0x00. With N_LAYERS=2 this reproduces the legacy rule: black on the higher plane shows the lower plane.
- Frame event: rising edge of vs_in, detected against a registered copy of vs_in.
- On a frame event, the active registers load the shadow registers.
- A cfg write in the same cycle as the commit updates the shadow only; it becomes active at the next frame event.
- Layer i is opaque iff enable[i] && !(keyen[i] && layer_rgb_i == key[i]).
- Pipeline, LATENCY = 3 fixed:
  - S1: register layer data and per-layer opaque flags.
  - S2: select the lowest-index opaque layer; if none is opaque, select the background.
  - S3: expand each channel to OUT_W bits. Value 0 gives all zeros; otherwise the channel bits are placed in the MSBs and the LSBs are filled with ones. Blue uses 2 source bits.
- If blank is high at S3, the colour outputs are forced to 0.
- hs/vs/blank pass through a 3-deep shift register, so outputs stay cycle-aligned with colour.
- frame_drawn is high for exactly one cycle, the cycle after a frame event is detected.
- frame_count increments on the same cycle that frame_drawn is high and wraps at 2^FRAME_CNT_W-1 to 0.
- Reset (async assert, no clock needed):
  - Colours = 0, hs_out = vs_out = 0, blank_out = 1.
  - frame_drawn = 0, frame_count = 0.
  - Pipeline and delay line cleared; shadow and active registers take their reset values.
  - The vs edge detector is cleared to 0. If vs_in is already high when reset is released, a frame event occurs on the first clock.
- Reset mid-frame: all in-flight pixels are discarded.
- Input held constant: the output is stable after 3 clocks.

Decomposition:
- Shared package fsx_pkg holds:
  - RGB332 field offsets.
  - Config addresses: CFG_EN=0, CFG_KEYEN=1, CFG_BG=2, CFG_KEY0=3.
  - LATENCY=3.
  - The expansion function (also used by encoders/sim dump).
- Sub-module fsx_cfg_regs holds shadow/active registers, commit and edge detect.
- Mixer pipeline stays in the top module.

Test Plan:
- Reset and priority:
  - Stimulus: reset, N_LAYERS=2, L0=0x00, L1=0xE0, blank=0.
  - Response: after 3 clocks r_out=0xFF, g_out=0, b_out=0 (L0 keyed black → L1 shows).
- Priority with layer disabled:
  - Stimulus: L0=0x1C, L1=0xE0.
  - Response: g_out=0xFF, r_out=0.
  - Stimulus: write CFG_EN=0x02, then a vs_in rising edge.
  - Response: the next pixel shows r_out=0xFF.
- Shadow timing:
  - Stimulus: write CFG_BG=0x03 mid-frame with all layers keyed.
  - Response: output stays 0 until after the vs edge, then b_out=0xFF.
  - Stimulus: a write coincident with the commit cycle.
  - Response: takes effect only a frame later.
- Blank/sync alignment:
  - Stimulus: toggle hs_in/blank_in with non-zero layers.
  - Response: hs_out/blank_out lag by exactly 3 cycles; colours are 0 exactly while blank_out=1.
- Interrupt and counter:
  - Stimulus: 3 vs_in pulses, each 5 cycles wide.
  - Response: exactly 3 single-cycle frame_drawn pulses; frame_count=3.
  - Stimulus: FRAME_CNT_W=2 with 5 pulses.
  - Response: wraps to 1.
- Async reset mid-pipeline:
  - Stimulus: assert reset between clock edges.
  - Response: outputs are immediately at reset values; after release the first 3 cycles output 0 colour with blank_out=1.
